// File: rtl/parallel_bus_capture.sv
// parallel_bus_capture
//   Capture stage for the 8-bit 8080-style parallel bus viewer. All bus pins
//   are synchronised into the clk domain through identical chains. Every
//   rising edge of wr that passes the cs qualifier records one transaction
//   (data byte plus control snapshot) into a show-ahead FIFO. The display
//   stage steps through the entries with a single-cycle next pulse.
//
// Ports
//   clk        in   system clock
//   nreset     in   synchronous, active-low reset
//   data       in   [7:0] async bus data pins
//   bus_reset  in   async bus reset pin (monitored only)
//   cs         in   async chip select, active low
//   dc         in   async data/command pin
//   wr         in   async write strobe, recorded on its rising edge
//   rd         in   async read strobe
//   next       in   pulse: pop the FIFO head
//   clear      in   pulse: empty the FIFO and clear overflow
//   out_data   out  [7:0] head data byte, 0 when empty
//   out_flags  out  [3:0] head {bus_reset, cs, dc, rd}, 0 when empty
//   out_valid  out  FIFO not empty
//   count      out  [FIFO_DEPTH_BITS:0] number of stored entries
//   overflow   out  sticky: a transaction was dropped on a full FIFO

module parallel_bus_capture #(
    parameter int unsigned FIFO_DEPTH_BITS = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter bit          CS_FILTER       = 1'b1
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic [7:0]               data,
    input  logic                     bus_reset,
    input  logic                     cs,
    input  logic                     dc,
    input  logic                     wr,
    input  logic                     rd,
    input  logic                     next,
    input  logic                     clear,
    output logic [7:0]               out_data,
    output logic [3:0]               out_flags,
    output logic                     out_valid,
    output logic [FIFO_DEPTH_BITS:0] count,
    output logic                     overflow
);

    localparam int unsigned LP_DEPTH = 1 << FIFO_DEPTH_BITS;

    // Chain word layout: {wr, bus_reset, cs, dc, rd, data[7:0]}.
    // Idle value keeps the strobes and cs inactive so reset release is quiet.
    localparam logic [12:0] LP_SYNC_IDLE = 13'b1_1_1_0_1_0000_0000;

    localparam logic [FIFO_DEPTH_BITS-1:0] LP_PTR_ONE = FIFO_DEPTH_BITS'(1);
    localparam logic [FIFO_DEPTH_BITS:0]   LP_CNT_ONE = (FIFO_DEPTH_BITS + 1)'(1);

    logic [12:0]                r_sync [SYNC_STAGES];
    logic                       r_wr_prev;
    logic [FIFO_DEPTH_BITS-1:0] r_wr_ptr;
    logic [FIFO_DEPTH_BITS-1:0] r_rd_ptr;
    logic [FIFO_DEPTH_BITS:0]   r_count;
    logic                       r_overflow;
    logic [11:0]                r_mem [LP_DEPTH];

    logic [12:0]                w_sync_out;
    logic                       w_wr_s;
    logic                       w_cs_s;
    logic [11:0]                w_word;
    logic                       w_wr_edge;
    logic                       w_push_req;
    logic                       w_full;
    logic                       w_empty;
    logic                       w_pop;
    logic                       w_push;
    logic                       w_drop;
    logic [FIFO_DEPTH_BITS-1:0] w_wr_ptr_nxt;
    logic [FIFO_DEPTH_BITS-1:0] w_rd_ptr_nxt;
    logic [FIFO_DEPTH_BITS:0]   w_count_nxt;
    logic                       w_overflow_nxt;
    logic [11:0]                w_head;

    // Synchronisers: every bus bit sees the same number of stages so the
    // data and control snapshot stays aligned with the strobe.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                r_sync[i] <= LP_SYNC_IDLE;
            end
        end else begin
            r_sync[0] <= {wr, bus_reset, cs, dc, rd, data};
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_wr_s     = w_sync_out[12];
    assign w_cs_s     = w_sync_out[10];
    // {bus_reset, cs, dc, rd, data} straight from the chain outputs.
    assign w_word     = w_sync_out[11:0];

    assign w_wr_edge  = w_wr_s & ~r_wr_prev;
    assign w_push_req = w_wr_edge & (!CS_FILTER | ~w_cs_s);

    // count never exceeds the depth, so its MSB alone marks full.
    assign w_full  = r_count[FIFO_DEPTH_BITS];
    assign w_empty = (r_count == '0);

    always_comb begin
        w_pop          = 1'b0;
        w_push         = 1'b0;
        w_drop         = 1'b0;
        w_wr_ptr_nxt   = r_wr_ptr;
        w_rd_ptr_nxt   = r_rd_ptr;
        w_count_nxt    = r_count;
        w_overflow_nxt = r_overflow;

        if (clear) begin
            // clear wins over a simultaneous push or pop; that push is lost silently.
            w_wr_ptr_nxt   = '0;
            w_rd_ptr_nxt   = '0;
            w_count_nxt    = '0;
            w_overflow_nxt = 1'b0;
        end else begin
            w_pop  = next & ~w_empty;
            // A pop in the same cycle frees the slot, so a full FIFO still accepts.
            w_push = w_push_req & (~w_full | w_pop);
            w_drop = w_push_req & w_full & ~w_pop;

            if (w_push) begin
                w_wr_ptr_nxt = r_wr_ptr + LP_PTR_ONE;
            end
            if (w_pop) begin
                w_rd_ptr_nxt = r_rd_ptr + LP_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                w_count_nxt = r_count + LP_CNT_ONE;
            end else if (w_pop && !w_push) begin
                w_count_nxt = r_count - LP_CNT_ONE;
            end
            if (w_drop) begin
                w_overflow_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_wr_prev  <= 1'b1;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_wr_prev  <= w_wr_s;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_count    <= w_count_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    // Storage needs no reset: entries are only visible while count covers them.
    always_ff @(posedge clk) begin
        if (nreset && w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    assign w_head    = r_mem[r_rd_ptr];
    assign out_valid = ~w_empty;
    assign out_data  = w_empty ? 8'h00 : w_head[7:0];
    assign out_flags = w_empty ? 4'h0  : w_head[11:8];
    assign count     = r_count;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_parallel_bus_capture.sv
// Directed bench for parallel_bus_capture with default parameters
// (depth 16, two sync stages, cs filtering on). Inputs are driven and
// outputs sampled on the falling clock edge.

module tb_parallel_bus_capture;

    logic       clk = 1'b0;
    logic       nreset;
    logic [7:0] data;
    logic       bus_reset;
    logic       cs;
    logic       dc;
    logic       wr;
    logic       rd;
    logic       next;
    logic       clear;
    logic [7:0] out_data;
    logic [3:0] out_flags;
    logic       out_valid;
    logic [4:0] count;
    logic       overflow;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    parallel_bus_capture #(
        .FIFO_DEPTH_BITS(4),
        .SYNC_STAGES    (2),
        .CS_FILTER      (1'b1)
    ) dut (
        .clk      (clk),
        .nreset   (nreset),
        .data     (data),
        .bus_reset(bus_reset),
        .cs       (cs),
        .dc       (dc),
        .wr       (wr),
        .rd       (rd),
        .next     (next),
        .clear    (clear),
        .out_data (out_data),
        .out_flags(out_flags),
        .out_valid(out_valid),
        .count    (count),
        .overflow (overflow)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // All tasks start and end on a falling edge.
    task automatic bus_write(input logic [7:0] d, input logic cs_v);
        data = d;
        cs   = cs_v;
        wr   = 1'b0;
        repeat (3) @(negedge clk);
        wr = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic pop();
        next = 1'b1;
        @(negedge clk);
        next = 1'b0;
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        nreset    = 1'b0;
        data      = 8'h00;
        bus_reset = 1'b1;
        cs        = 1'b1;
        dc        = 1'b1;
        wr        = 1'b1;
        rd        = 1'b1;
        next      = 1'b0;
        clear     = 1'b0;
        repeat (4) @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);

        // Reset state
        check_eq("rst valid", out_valid, 1'b0);
        check_eq("rst count", count, 5'd0);
        check_eq("rst data", out_data, 8'h00);
        check_eq("rst flags", out_flags, 4'h0);
        check_eq("rst overflow", overflow, 1'b0);

        // Test 1: single write, two-edge latency, flags snapshot
        data = 8'hA5;
        cs   = 1'b0;
        dc   = 1'b1;
        wr   = 1'b0;
        repeat (3) @(negedge clk);
        wr = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("t1 count before k+2", count, 5'd0);
        @(negedge clk);
        check_eq("t1 count", count, 5'd1);
        check_eq("t1 valid", out_valid, 1'b1);
        check_eq("t1 data", out_data, 8'hA5);
        check_eq("t1 flags", out_flags, 4'b1011);
        pop();
        check_eq("t1 valid after pop", out_valid, 1'b0);
        check_eq("t1 data after pop", out_data, 8'h00);
        check_eq("t1 flags after pop", out_flags, 4'h0);

        // Test 2: cs filtering and ordering
        for (int i = 0; i < 3; i++) bus_write(8'hE0 + 8'(i), 1'b1);
        check_eq("t2 filtered count", count, 5'd0);
        for (int i = 1; i <= 3; i++) bus_write(8'(i), 1'b0);
        check_eq("t2 count", count, 5'd3);
        check_eq("t2 head 1", out_data, 8'h01);
        pop();
        check_eq("t2 head 2", out_data, 8'h02);
        pop();
        check_eq("t2 head 3", out_data, 8'h03);
        pop();
        check_eq("t2 empty", out_valid, 1'b0);

        // Test 3: overflow on 17 writes
        for (int i = 0; i <= 16; i++) bus_write(8'(i), 1'b0);
        check_eq("t3 count full", count, 5'd16);
        check_eq("t3 overflow set", overflow, 1'b1);
        check_eq("t3 head", out_data, 8'h00);
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("t3 pop %0d", i), out_data, 32'(i));
            pop();
        end
        check_eq("t3 drained", out_valid, 1'b0);
        check_eq("t3 overflow sticky", overflow, 1'b1);
        clear_pulse();
        check_eq("t3 overflow cleared", overflow, 1'b0);

        // Test 4: push and pop together while full
        for (int i = 0; i < 16; i++) bus_write(8'h20 + 8'(i), 1'b0);
        check_eq("t4 count full", count, 5'd16);
        data = 8'h55;
        wr   = 1'b0;
        repeat (3) @(negedge clk);
        wr = 1'b1;
        repeat (2) @(negedge clk);
        next = 1'b1;
        @(negedge clk);
        next = 1'b0;
        check_eq("t4 count after push+pop", count, 5'd16);
        check_eq("t4 no overflow", overflow, 1'b0);
        repeat (2) @(negedge clk);
        check_eq("t4 count settled", count, 5'd16);
        for (int i = 0; i < 15; i++) begin
            check_eq($sformatf("t4 pop %0d", i), out_data, 32'h21 + 32'(i));
            pop();
        end
        check_eq("t4 last entry", out_data, 8'h55);
        pop();
        check_eq("t4 drained", out_valid, 1'b0);

        // Test 5: pointer wrap-around
        for (int i = 0; i < 10; i++) bus_write(8'h40 + 8'(i), 1'b0);
        check_eq("t5 first fill", count, 5'd10);
        for (int i = 0; i < 10; i++) pop();
        check_eq("t5 first drain", count, 5'd0);
        for (int i = 0; i < 10; i++) bus_write(8'h80 + 8'(i), 1'b0);
        for (int i = 0; i < 10; i++) begin
            check_eq($sformatf("t5 count %0d", i), count, 32'(10 - i));
            check_eq($sformatf("t5 data %0d", i), out_data, 32'h80 + 32'(i));
            pop();
        end
        check_eq("t5 count end", count, 5'd0);

        // Test 6: clear beats a simultaneous push
        for (int i = 0; i < 5; i++) bus_write(8'h60 + 8'(i), 1'b0);
        check_eq("t6 count 5", count, 5'd5);
        data = 8'h77;
        wr   = 1'b0;
        repeat (3) @(negedge clk);
        wr = 1'b1;
        repeat (2) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_eq("t6 count cleared", count, 5'd0);
        check_eq("t6 valid cleared", out_valid, 1'b0);
        check_eq("t6 overflow cleared", overflow, 1'b0);
        @(negedge clk);
        check_eq("t6 push lost", count, 5'd0);

        // Test 6b: reset while wr is low, then a single rising edge
        data = 8'h3C;
        wr   = 1'b0;
        @(negedge clk);
        nreset = 1'b0;
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("t6 no edge after reset", count, 5'd0);
        wr = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("t6 one entry", count, 5'd1);
        check_eq("t6 entry data", out_data, 8'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
